uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: frame geometry, FSM encoding and parity helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 8;
    localparam int DATA_BITS    = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } rx_state_t;
`endif

    // Even-parity bit: makes the total count of ones across data and parity even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable so the
// bit-period phase lines up with a detected start edge.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV_C = (DIV < 1) ? 1 : DIV;
    localparam int CW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter with registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (restart) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CW'(DIV_C - 1)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with 16x oversampling
// and an inline receive FIFO exposing a valid/ready interface.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    logic                 rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t            state_r;
    logic [TW-1:0]        tick_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bad_r;
    logic                 frame_err_r;
    logic                 tick_s, restart_s, sample_s, push_s;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]        count_r, count_n_s;
    logic                 rx_valid_r, overrun_r;
    logic [DATA_BITS-1:0] rx_data_r, head_n_s;
    logic                 full_s, pop_s, do_push_s;

    // Two-flop synchronizer plus previous-value flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Start detection, mid-bit sample strobe and accepted-byte strobe.
    always_comb begin
        restart_s = 1'b0;
        if ((state_r == ST_IDLE) && rx_prev_r && !rx_sync_r) begin
            restart_s = 1'b1;
        end else begin
            restart_s = 1'b0;
        end
        sample_s = tick_s && (tick_cnt_r == TW'(SAMPLE_POINT - 1));
        push_s   = (state_r == ST_STOP) && sample_s && rx_sync_r && !par_bad_r;
    end

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Frame FSM; a low stop bit returns to IDLE with rx low, so no new start until rx rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            par_bad_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (tick_s) begin
                tick_cnt_r <= tick_cnt_r + TW'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (restart_s) begin
                        state_r    <= ST_START;
                        tick_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                        par_bad_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_s) begin
                        state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_r   <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                        if (bit_cnt_r == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_s) begin
                        par_bad_r <= (rx_sync_r != even_parity(shift_r));
                        state_r   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_s) begin
                        frame_err_r <= !rx_sync_r || par_bad_r;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO next-state: pop is applied before push, so a full FIFO still accepts on a pop cycle.
    always_comb begin
        full_s    = (count_r == CW'(FIFO_DEPTH));
        pop_s     = rx_valid_r && rx_ready;
        do_push_s = push_s && (!full_s || pop_s);
        rd_next_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        count_n_s = count_r;
        if (do_push_s && !pop_s) begin
            count_n_s = count_r + CW'(1);
        end else if (!do_push_s && pop_s) begin
            count_n_s = count_r - CW'(1);
        end else begin
            count_n_s = count_r;
        end
        if (do_push_s && (rd_next_s == wr_ptr_r)) begin
            head_n_s = shift_r;
        end else begin
            head_n_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and registered head/valid/overrun outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
            overrun_r  <= 1'b0;
        end else begin
            overrun_r <= push_s && full_s && !pop_s;
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r   <= rd_next_s;
            count_r    <= count_n_s;
            rx_valid_r <= (count_n_s != '0);
            if (count_n_s != '0) begin
                rx_data_r <= head_n_s;
            end
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule
